sample_clock_gen: RTL

- Programmable divider that produces the square-wave sample-rate clock `sample_clock` from CLK_50M.
- `sample_clock` feeds the edge detector, which turns it into one-cycle start strobes for the audio path.
- Playback speed is adjusted by one-cycle speed_up / speed_down / speed_reset pulses from the keyboard/button control logic.
- A new rate never causes a runt or stretched half-period: changes are applied only at a toggle boundary.

---
 rtl/sample_clock_gen.sv | 83 ++++++++
 1 files changed

// File: rtl/sample_clock_gen.sv
// Programmable square-wave divider producing sample_clock from CLK_50M.
// Rate requests are saturated, and they take effect only when sample_clock toggles.
module sample_clock_gen #(
   parameter int WIDTH        = 16,
   parameter int DEFAULT_HALF = 1136,
   parameter int STEP         = 32,
   parameter int MIN_HALF     = 256,
   parameter int MAX_HALF     = 4095
) (
   input  logic             CLK_50M,
   input  logic             reset,
   input  logic             enable,
   input  logic             speed_up,
   input  logic             speed_down,
   input  logic             speed_reset,
   output logic             sample_clock,
   output logic [WIDTH-1:0] half_period,
   output logic             at_min,
   output logic             at_max
);

   localparam logic [WIDTH:0]   STEP_W    = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0]   MIN_W     = (WIDTH+1)'(MIN_HALF);
   localparam logic [WIDTH:0]   MAX_W     = (WIDTH+1)'(MAX_HALF);
   localparam logic [WIDTH-1:0] MIN_N     = WIDTH'(MIN_HALF);
   localparam logic [WIDTH-1:0] MAX_N     = WIDTH'(MAX_HALF);
   localparam logic [WIDTH-1:0] DEFAULT_N = WIDTH'(DEFAULT_HALF);
   localparam logic [WIDTH-1:0] ONE_N     = WIDTH'(1);

   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] active_half;
   logic [WIDTH-1:0] half_next;
   logic [WIDTH:0]   hp_wide;
   logic [WIDTH:0]   hp_dec;
   logic [WIDTH:0]   hp_inc;

   // One extra bit makes an underflow visible as a set MSB instead of a wrap.
   always_comb begin
      hp_wide   = {1'b0, half_period};
      hp_dec    = hp_wide - STEP_W;
      hp_inc    = hp_wide + STEP_W;
      half_next = half_period;
      if (speed_reset) begin
         half_next = DEFAULT_N;
      end else if (speed_up && speed_down) begin
         half_next = half_period;
      end else if (speed_up) begin
         half_next = (hp_dec[WIDTH] || (hp_dec < MIN_W)) ? MIN_N : hp_dec[WIDTH-1:0];
      end else if (speed_down) begin
         half_next = (hp_inc > MAX_W) ? MAX_N : hp_inc[WIDTH-1:0];
      end
   end

   always_ff @(posedge CLK_50M or negedge reset) begin
      if (!reset) begin
         half_period <= DEFAULT_N;
         at_min      <= (DEFAULT_HALF == MIN_HALF);
         at_max      <= (DEFAULT_HALF == MAX_HALF);
      end else begin
         half_period <= half_next;
         at_min      <= (half_next == MIN_N);
         at_max      <= (half_next == MAX_N);
      end
   end

   // active_half is loaded only at the toggle, so a level always completes at its starting length.
   always_ff @(posedge CLK_50M or negedge reset) begin
      if (!reset) begin
         count        <= '0;
         sample_clock <= 1'b0;
         active_half  <= DEFAULT_N;
      end else if (enable) begin
         if (count == active_half - ONE_N) begin
            count        <= '0;
            sample_clock <= ~sample_clock;
            active_half  <= half_period;
         end else begin
            count <= count + ONE_N;
         end
      end
   end

endmodule
